attr_port_ctrl: RTL and testbench

Host-side register controller for the VGA attribute controller. Implements the index/data flip-flop on port 0x3C0, readback on 0x3C1/0x3C0, and the flip-flop reset caused by reading 0x3DA. Decodes attribute registers 0x00–0x14 into the palette-write strobes and static configuration inputs of the attribute datapath. Sits between the host I/O decoder and the attribute datapath, in the dot-clock domain.

---
 rtl/attr_port_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_attr_port_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/attr_port_ctrl.sv
// attr_port_ctrl: host register controller for the VGA attribute block.
// Handles the 0x3C0 index/data flip-flop, readback on 0x3C0/0x3C1, the
// flip-flop reset from a 0x3DA read, and decodes attribute registers
// 0x00-0x14 into palette write strobes and static datapath configuration.
// Optional feature: define ATTR_PAL_READBACK_EN to keep a 16x6 shadow copy
// of the palette so that 0x3C1 reads of indices 0x00-0x0F return real data.
module attr_port_ctrl (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       wr_3c0_i,
  input  logic       rd_3c0_i,
  input  logic       rd_3c1_i,
  input  logic       rd_3da_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic       ff_data_o,
  output logic       pas_o,
  output logic       pal_write_o,
  output logic [3:0] pal_addr_o,
  output logic [5:0] pal_data_o,
  output logic       textmode_o,
  output logic       monotext_o,
  output logic       linechr_mode_o,
  output logic       textblink_o,
  output logic       splitpanning_o,
  output logic       colour256_o,
  output logic       coloursel4_o,
  output logic [7:0] overscan_clr_o,
  output logic [3:0] plane_en_o,
  output logic [1:0] status_sel_o,
  output logic [3:0] horiz_pan_o,
  output logic [3:0] coloursel_o
);

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } ff_state_e;

  ff_state_e  state_q, state_d;
  logic [4:0] index_q, index_d;
  logic       pas_q, pas_d;

  // Mode register is kept with bit 4 forced to zero so readback shows
  // unused bits as 0 without an extra mask on the read path.
  logic [7:0] mode_q, mode_d;
  logic [7:0] overscan_q, overscan_d;
  logic [3:0] plane_en_q, plane_en_d;
  logic [1:0] status_sel_q, status_sel_d;
  logic [3:0] horiz_pan_q, horiz_pan_d;
  logic [3:0] coloursel_q, coloursel_d;

  logic       pal_write_q, pal_write_d;
  logic [3:0] pal_addr_q, pal_addr_d;
  logic [5:0] pal_data_q, pal_data_d;

  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;

  logic [7:0] reg_rd_val;
  logic       data_wr;
  logic       pal_wr_ok;

  // A 0x3C0 write in DATA state targets the register selected by index_q.
  assign data_wr   = wr_3c0_i && (state_q == ST_DATA);
  // Palette writes are dropped while the display owns the palette (pas=1).
  assign pal_wr_ok = data_wr && !index_q[4] && !pas_q;

`ifdef ATTR_PAL_READBACK_EN
  logic [5:0] shadow_q [16];
  logic [5:0] shadow_d [16];

  // Shadow palette next value: mirror every accepted palette write.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      shadow_d[i] = shadow_q[i];
    end
    if (pal_wr_ok) begin
      shadow_d[index_q[3:0]] = wr_data_i[5:0];
    end
  end

  // Shadow palette storage, cleared on reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= 6'h00;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end
`endif

  // Flip-flop next state: index writes go to DATA, data writes return to
  // ADDR, and a 0x3DA read overrides the result back to ADDR.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    pas_d   = pas_q;
    if (wr_3c0_i) begin
      if (state_q == ST_ADDR) begin
        index_d = wr_data_i[4:0];
        pas_d   = wr_data_i[5];
        state_d = ST_DATA;
      end else begin
        state_d = ST_ADDR;
      end
    end
    if (rd_3da_i) begin
      state_d = ST_ADDR;
    end
  end

  // Flip-flop state register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_ADDR;
      index_q <= 5'h00;
      pas_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      pas_q   <= pas_d;
    end
  end

  // Configuration register decode for indices 0x10-0x14; others ignored.
  always_comb begin
    mode_d       = mode_q;
    overscan_d   = overscan_q;
    plane_en_d   = plane_en_q;
    status_sel_d = status_sel_q;
    horiz_pan_d  = horiz_pan_q;
    coloursel_d  = coloursel_q;
    if (data_wr) begin
      case (index_q)
        5'h10: mode_d = wr_data_i & 8'hEF;
        5'h11: overscan_d = wr_data_i;
        5'h12: begin
          plane_en_d   = wr_data_i[3:0];
          status_sel_d = wr_data_i[5:4];
        end
        5'h13: horiz_pan_d = wr_data_i[3:0];
        5'h14: coloursel_d = wr_data_i[3:0];
        default: ;
      endcase
    end
  end

  // Configuration registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      mode_q       <= 8'h00;
      overscan_q   <= 8'h00;
      plane_en_q   <= 4'hF;
      status_sel_q <= 2'b00;
      horiz_pan_q  <= 4'h0;
      coloursel_q  <= 4'h0;
    end else begin
      mode_q       <= mode_d;
      overscan_q   <= overscan_d;
      plane_en_q   <= plane_en_d;
      status_sel_q <= status_sel_d;
      horiz_pan_q  <= horiz_pan_d;
      coloursel_q  <= coloursel_d;
    end
  end

  // Palette write port: one-cycle strobe, address/data held between writes.
  always_comb begin
    pal_write_d = 1'b0;
    pal_addr_d  = pal_addr_q;
    pal_data_d  = pal_data_q;
    if (pal_wr_ok) begin
      pal_write_d = 1'b1;
      pal_addr_d  = index_q[3:0];
      pal_data_d  = wr_data_i[5:0];
    end
  end

  // Palette write port registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pal_write_q <= 1'b0;
      pal_addr_q  <= 4'h0;
      pal_data_q  <= 6'h00;
    end else begin
      pal_write_q <= pal_write_d;
      pal_addr_q  <= pal_addr_d;
      pal_data_q  <= pal_data_d;
    end
  end

  // Register readback mux, built from pre-write register contents.
  always_comb begin
    reg_rd_val = 8'h00;
    case (index_q)
      5'h10: reg_rd_val = mode_q;
      5'h11: reg_rd_val = overscan_q;
      5'h12: reg_rd_val = {2'b00, status_sel_q, plane_en_q};
      5'h13: reg_rd_val = {4'h0, horiz_pan_q};
      5'h14: reg_rd_val = {4'h0, coloursel_q};
      default: begin
`ifdef ATTR_PAL_READBACK_EN
        if (!index_q[4]) begin
          reg_rd_val = {2'b00, shadow_q[index_q[3:0]]};
        end
`endif
      end
    endcase
  end

  // Read response: 0x3C1 has priority over 0x3C0; data holds between reads.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_3c0_i || rd_3c1_i;
    if (rd_3c1_i) begin
      rd_data_d = reg_rd_val;
    end else if (rd_3c0_i) begin
      rd_data_d = {2'b00, pas_q, index_q};
    end
  end

  // Read response registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign ff_data_o      = (state_q == ST_DATA);
  assign pas_o          = pas_q;
  assign pal_write_o    = pal_write_q;
  assign pal_addr_o     = pal_addr_q;
  assign pal_data_o     = pal_data_q;
  assign textmode_o     = ~mode_q[0];
  assign monotext_o     = mode_q[1];
  assign linechr_mode_o = mode_q[2];
  assign textblink_o    = mode_q[3];
  assign splitpanning_o = mode_q[5];
  assign colour256_o    = mode_q[6];
  assign coloursel4_o   = mode_q[7];
  assign overscan_clr_o = overscan_q;
  assign plane_en_o     = plane_en_q;
  assign status_sel_o   = status_sel_q;
  assign horiz_pan_o    = horiz_pan_q;
  assign coloursel_o    = coloursel_q;

endmodule

// File: tb/tb_attr_port_ctrl.sv
// tb_attr_port_ctrl: directed scenarios plus randomized traffic checked
// against a register-map level model of the attribute port controller.
module tb_attr_port_ctrl;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       wr_3c0_i, rd_3c0_i, rd_3c1_i, rd_3da_i;
  logic [7:0] wr_data_i;
  logic [7:0] rd_data_o;
  logic       rd_valid_o, ff_data_o, pas_o, pal_write_o;
  logic [3:0] pal_addr_o;
  logic [5:0] pal_data_o;
  logic       textmode_o, monotext_o, linechr_mode_o, textblink_o;
  logic       splitpanning_o, colour256_o, coloursel4_o;
  logic [7:0] overscan_clr_o;
  logic [3:0] plane_en_o;
  logic [1:0] status_sel_o;
  logic [3:0] horiz_pan_o;
  logic [3:0] coloursel_o;

  int total = 0;
  int bad   = 0;

  attr_port_ctrl dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .wr_3c0_i(wr_3c0_i), .rd_3c0_i(rd_3c0_i), .rd_3c1_i(rd_3c1_i),
    .rd_3da_i(rd_3da_i), .wr_data_i(wr_data_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .ff_data_o(ff_data_o),
    .pas_o(pas_o), .pal_write_o(pal_write_o), .pal_addr_o(pal_addr_o),
    .pal_data_o(pal_data_o), .textmode_o(textmode_o), .monotext_o(monotext_o),
    .linechr_mode_o(linechr_mode_o), .textblink_o(textblink_o),
    .splitpanning_o(splitpanning_o), .colour256_o(colour256_o),
    .coloursel4_o(coloursel4_o), .overscan_clr_o(overscan_clr_o),
    .plane_en_o(plane_en_o), .status_sel_o(status_sel_o),
    .horiz_pan_o(horiz_pan_o), .coloursel_o(coloursel_o)
  );

  always #5 clock_i = ~clock_i;

  // Reference model: readable value of each of the 32 attribute addresses.
  logic [7:0] m_reg [32];
  logic [4:0] m_idx;
  logic       m_pas, m_ff, m_rd_valid, m_pw;
  logic [7:0] m_rd_data;
  logic [3:0] m_pa;
  logic [5:0] m_pd;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 8'h00;
    m_reg[18] = 8'h0F;
    m_idx = 5'h00; m_pas = 1'b0; m_ff = 1'b0;
    m_rd_valid = 1'b0; m_rd_data = 8'h00;
    m_pw = 1'b0; m_pa = 4'h0; m_pd = 6'h00;
  endtask

  function automatic logic [7:0] m_read(input logic [4:0] a);
    if (a < 5'd16) begin
`ifdef ATTR_PAL_READBACK_EN
      return m_reg[a];
`else
      return 8'h00;
`endif
    end
    return m_reg[a];
  endfunction

  function automatic logic [7:0] m_pal_readback(input logic [7:0] v);
`ifdef ATTR_PAL_READBACK_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction

  // One clock of stimulus; the model is advanced to match the edge.
  task automatic step(input logic w, input logic r0, input logic r1,
                      input logic r3, input logic [7:0] d);
    logic [7:0] rv;
    wr_3c0_i = w; rd_3c0_i = r0; rd_3c1_i = r1; rd_3da_i = r3; wr_data_i = d;
    rv = r1 ? m_read(m_idx) : {2'b00, m_pas, m_idx};
    @(posedge clock_i);
    #1;
    wr_3c0_i = 1'b0; rd_3c0_i = 1'b0; rd_3c1_i = 1'b0; rd_3da_i = 1'b0;
    m_pw = 1'b0;
    if (r0 || r1) m_rd_data = rv;
    m_rd_valid = r0 || r1;
    if (w) begin
      if (!m_ff) begin
        m_idx = d[4:0]; m_pas = d[5]; m_ff = 1'b1;
      end else begin
        if (m_idx < 5'd16) begin
          if (!m_pas) begin
            m_pw = 1'b1; m_pa = m_idx[3:0]; m_pd = d[5:0];
            m_reg[m_idx] = {2'b00, d[5:0]};
          end
        end else begin
          case (m_idx)
            5'h10: m_reg[16] = d & 8'hEF;
            5'h11: m_reg[17] = d;
            5'h12: m_reg[18] = d & 8'h3F;
            5'h13: m_reg[19] = d & 8'h0F;
            5'h14: m_reg[20] = d & 8'h0F;
            default: ;
          endcase
        end
        m_ff = 1'b0;
      end
    end
    if (r3) m_ff = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    wr_3c0_i = 1'b0; rd_3c0_i = 1'b0; rd_3c1_i = 1'b0; rd_3da_i = 1'b0;
    wr_data_i = 8'h00;
    model_reset();
    #12;
    total++; if (ff_data_o !== 1'b0) begin bad++; $display("FAIL reset_ff: got %b want 0", ff_data_o); end
    total++; if (pas_o !== 1'b0) begin bad++; $display("FAIL reset_pas: got %b want 0", pas_o); end
    total++; if ({textmode_o, monotext_o, linechr_mode_o, textblink_o, splitpanning_o, colour256_o, coloursel4_o} !== 7'b1000000) begin
      bad++; $display("FAIL reset_mode: got %b want 1000000", {textmode_o, monotext_o, linechr_mode_o, textblink_o, splitpanning_o, colour256_o, coloursel4_o}); end
    total++; if (plane_en_o !== 4'hF) begin bad++; $display("FAIL reset_plane: got %h want f", plane_en_o); end
    total++; if ({overscan_clr_o, status_sel_o, horiz_pan_o, coloursel_o} !== 18'h0) begin
      bad++; $display("FAIL reset_cfg: got %h want 0", {overscan_clr_o, status_sel_o, horiz_pan_o, coloursel_o}); end
    total++; if ({pal_write_o, pal_addr_o, pal_data_o} !== 11'h0) begin
      bad++; $display("FAIL reset_pal: got %h want 0", {pal_write_o, pal_addr_o, pal_data_o}); end
    total++; if ({rd_valid_o, rd_data_o} !== 9'h0) begin
      bad++; $display("FAIL reset_rd: got %h want 0", {rd_valid_o, rd_data_o}); end
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  task automatic test_palette_write();
    step(1, 0, 0, 0, 8'h03);
    total++; if (ff_data_o !== 1'b1) begin bad++; $display("FAIL pal_ff_after_index: got %b want 1", ff_data_o); end
    total++; if (pal_write_o !== 1'b0) begin bad++; $display("FAIL pal_no_early_write: got %b want 0", pal_write_o); end
    step(1, 0, 0, 0, 8'h2A);
    total++; if ({pal_write_o, pal_addr_o, pal_data_o} !== {1'b1, 4'h3, 6'h2A}) begin
      bad++; $display("FAIL pal_write: got %b/%h/%h want 1/3/2a", pal_write_o, pal_addr_o, pal_data_o); end
    total++; if (ff_data_o !== 1'b0) begin bad++; $display("FAIL pal_ff_after_data: got %b want 0", ff_data_o); end
    step(0, 0, 0, 0, 8'h00);
    total++; if ({pal_write_o, pal_addr_o, pal_data_o} !== {1'b0, 4'h3, 6'h2A}) begin
      bad++; $display("FAIL pal_pulse_hold: got %b/%h/%h want 0/3/2a", pal_write_o, pal_addr_o, pal_data_o); end
  endtask

  task automatic test_mode_and_index_read();
    step(1, 0, 0, 0, 8'h30);
    step(1, 0, 0, 0, 8'h41);
    total++; if ({textmode_o, monotext_o, linechr_mode_o, textblink_o, splitpanning_o, colour256_o, coloursel4_o} !== 7'b0000010) begin
      bad++; $display("FAIL mode_bits: got %b want 0000010", {textmode_o, monotext_o, linechr_mode_o, textblink_o, splitpanning_o, colour256_o, coloursel4_o}); end
    total++; if (pas_o !== 1'b1) begin bad++; $display("FAIL mode_pas: got %b want 1", pas_o); end
    step(0, 1, 0, 0, 8'h00);
    total++; if ({rd_valid_o, rd_data_o} !== {1'b1, 8'h30}) begin
      bad++; $display("FAIL index_read: got %b/%h want 1/30", rd_valid_o, rd_data_o); end
    step(0, 0, 0, 0, 8'h00);
    total++; if ({rd_valid_o, rd_data_o} !== {1'b0, 8'h30}) begin
      bad++; $display("FAIL read_hold: got %b/%h want 0/30", rd_valid_o, rd_data_o); end
    step(0, 1, 1, 0, 8'h00);
    total++; if ({rd_valid_o, rd_data_o} !== {1'b1, 8'h41}) begin
      bad++; $display("FAIL data_read_priority: got %b/%h want 1/41", rd_valid_o, rd_data_o); end
  endtask

  task automatic test_pas_discard();
    logic [7:0] want;
    step(1, 0, 0, 0, 8'h05);
    step(1, 0, 0, 0, 8'h15);
    total++; if ({pal_write_o, pal_addr_o, pal_data_o} !== {1'b1, 4'h5, 6'h15}) begin
      bad++; $display("FAIL pas0_write: got %b/%h/%h want 1/5/15", pal_write_o, pal_addr_o, pal_data_o); end
    step(1, 0, 0, 0, 8'h25);
    step(1, 0, 0, 0, 8'h11);
    total++; if ({pal_write_o, ff_data_o, pas_o} !== 3'b001) begin
      bad++; $display("FAIL pas1_discard: got %b want 001", {pal_write_o, ff_data_o, pas_o}); end
    step(0, 0, 1, 0, 8'h00);
    want = m_pal_readback(8'h15);
    total++; if (rd_data_o !== want) begin
      bad++; $display("FAIL pas1_readback: got %h want %h", rd_data_o, want); end
  endtask

  task automatic test_3da_reset();
    step(1, 0, 0, 0, 8'h12);
    step(0, 0, 0, 1, 8'h00);
    total++; if (ff_data_o !== 1'b0) begin bad++; $display("FAIL 3da_clear: got %b want 0", ff_data_o); end
    step(1, 0, 0, 0, 8'h3F);
    total++; if (ff_data_o !== 1'b1) begin bad++; $display("FAIL 3da_then_index: got %b want 1", ff_data_o); end
    total++; if (plane_en_o !== 4'hF) begin bad++; $display("FAIL 3da_plane_kept: got %h want f", plane_en_o); end
    step(1, 0, 0, 0, 8'h00);
  endtask

  task automatic test_3da_same_cycle();
    step(1, 0, 0, 0, 8'h13);
    step(1, 0, 0, 1, 8'h07);
    total++; if (horiz_pan_o !== 4'h7) begin bad++; $display("FAIL 3da_same_pan: got %h want 7", horiz_pan_o); end
    total++; if (ff_data_o !== 1'b0) begin bad++; $display("FAIL 3da_same_ff: got %b want 0", ff_data_o); end
  endtask

  task automatic test_unused_reg();
    step(1, 0, 0, 0, 8'h18);
    step(1, 0, 0, 0, 8'hFF);
    total++; if ({overscan_clr_o, plane_en_o, status_sel_o, horiz_pan_o, coloursel_o} !==
                 {m_reg[17], m_reg[18][3:0], m_reg[18][5:4], m_reg[19][3:0], m_reg[20][3:0]}) begin
      bad++; $display("FAIL unused_no_change: got %h", {overscan_clr_o, plane_en_o, status_sel_o, horiz_pan_o, coloursel_o}); end
    total++; if ({pal_write_o, textmode_o, colour256_o} !== 3'b001) begin
      bad++; $display("FAIL unused_no_pal_mode: got %b want 001", {pal_write_o, textmode_o, colour256_o}); end
    total++; if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL unused_valid_idle: got %b want 0", rd_valid_o); end
    step(0, 0, 1, 0, 8'h00);
    total++; if ({rd_valid_o, rd_data_o} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL unused_read: got %b/%h want 1/00", rd_valid_o, rd_data_o); end
  endtask

  task automatic test_reset_mid_data();
    step(1, 0, 0, 0, 8'h11);
    #3;
    reset_i = 1'b1;
    #1;
    model_reset();
    total++; if (ff_data_o !== 1'b0) begin bad++; $display("FAIL midreset_ff: got %b want 0", ff_data_o); end
    total++; if ({plane_en_o, horiz_pan_o, textmode_o} !== {4'hF, 4'h0, 1'b1}) begin
      bad++; $display("FAIL midreset_cfg: got %h", {plane_en_o, horiz_pan_o, textmode_o}); end
    @(negedge clock_i);
    reset_i = 1'b0;
    step(1, 0, 0, 0, 8'h2A);
    total++; if ({ff_data_o, pas_o, overscan_clr_o} !== {1'b1, 1'b1, 8'h00}) begin
      bad++; $display("FAIL midreset_lost_write: got %b/%b/%h want 1/1/00", ff_data_o, pas_o, overscan_clr_o); end
  endtask

  task automatic test_random();
    logic       w, r0, r1, r3;
    logic [7:0] d;
    for (int n = 0; n < 800; n++) begin
      w  = ($urandom_range(0, 1) == 1);
      r0 = ($urandom_range(0, 3) == 0);
      r1 = ($urandom_range(0, 3) == 0);
      r3 = ($urandom_range(0, 7) == 0);
      d  = 8'($urandom);
      if (!m_ff) begin
        d[4:0] = 5'($urandom_range(0, 22));
        d[5]   = ($urandom_range(0, 3) == 0);
      end
      step(w, r0, r1, r3, d);
      total++; if ({ff_data_o, pas_o} !== {m_ff, m_pas}) begin
        bad++; $display("FAIL rnd_ff_pas n=%0d: got %b%b want %b%b", n, ff_data_o, pas_o, m_ff, m_pas); end
      total++; if ({pal_write_o, pal_addr_o, pal_data_o} !== {m_pw, m_pa, m_pd}) begin
        bad++; $display("FAIL rnd_pal n=%0d: got %b/%h/%h want %b/%h/%h", n, pal_write_o, pal_addr_o, pal_data_o, m_pw, m_pa, m_pd); end
      total++; if ({textmode_o, monotext_o, linechr_mode_o, textblink_o, splitpanning_o, colour256_o, coloursel4_o} !==
                   {~m_reg[16][0], m_reg[16][1], m_reg[16][2], m_reg[16][3], m_reg[16][5], m_reg[16][6], m_reg[16][7]}) begin
        bad++; $display("FAIL rnd_mode n=%0d: got %b reg %h", n, {textmode_o, monotext_o, linechr_mode_o, textblink_o, splitpanning_o, colour256_o, coloursel4_o}, m_reg[16]); end
      total++; if ({overscan_clr_o, plane_en_o, status_sel_o, horiz_pan_o, coloursel_o} !==
                   {m_reg[17], m_reg[18][3:0], m_reg[18][5:4], m_reg[19][3:0], m_reg[20][3:0]}) begin
        bad++; $display("FAIL rnd_cfg n=%0d: got %h want %h", n, {overscan_clr_o, plane_en_o, status_sel_o, horiz_pan_o, coloursel_o},
                        {m_reg[17], m_reg[18][3:0], m_reg[18][5:4], m_reg[19][3:0], m_reg[20][3:0]}); end
      total++; if ({rd_valid_o, rd_data_o} !== {m_rd_valid, m_rd_data}) begin
        bad++; $display("FAIL rnd_read n=%0d: got %b/%h want %b/%h", n, rd_valid_o, rd_data_o, m_rd_valid, m_rd_data); end
    end
  endtask

  initial begin
    test_reset();
    test_palette_write();
    test_mode_and_index_read();
    test_pas_discard();
    test_3da_reset();
    test_3da_same_cycle();
    test_unused_reg();
    test_reset_mid_data();
    step(1, 0, 0, 0, 8'h00);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
